// File: rtl/mix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_pkg : constants and types shared by the forward mixer and its inverse   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mix_pkg;

  localparam int WORDS    = 8;
  localparam int W        = 32;
  localparam int SHIFT    = 16;
  localparam int XOR_DIST = 3;
  localparam int IDX_W    = 3;

  // Element i sits at [i]; the concatenations below list word 7 first.
  localparam logic [WORDS-1:0][W-1:0] K = {
    32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3
  };
  localparam logic [WORDS-1:0][W-1:0] C = {
    32'd29, 32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5
  };
  localparam logic [WORDS-1:0][W-1:0] KINV = {
    32'hE9BD37A7, 32'h286BCA1B, 32'hF0F0F0F1, 32'hC4EC4EC5,
    32'hBA2E8BA3, 32'hB6DB6DB7, 32'hCCCCCCCD, 32'hAAAAAAAB
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INV_C = 3'd1,
    INV_B = 3'd2,
    INV_A = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_INV_C = 2'd1,
    OP_INV_B = 2'd2,
    OP_INV_A = 2'd3
  } alu_op_t;

  // Every multiplier must have its modular inverse, otherwise unmixing is lossy.
  function automatic logic consts_ok();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      if (W'(K[i] * KINV[i]) != W'(1)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_word_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_word_alu : single-word inverse step; one multiplier shared by all words|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mix_word_alu
  import mix_pkg::*;
(
  input  alu_op_t          i_op,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [W-1:0]     i_word,
  input  logic [W-1:0]     i_nb,
  output logic [W-1:0]     o_word
);

  logic [W-1:0] w_diff;

  always_comb begin
    w_diff = i_word - C[i_idx];
    o_word = i_word;
    case (i_op)
      OP_INV_C: o_word = w_diff * KINV[i_idx];
      OP_INV_B: o_word = i_word ^ (i_nb << SHIFT);
      OP_INV_A: o_word = i_word - i_nb;
      default:  o_word = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mix_round_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_round_inverse : iterative unmix of ROUNDS forward rounds, 1 word/clock |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mix_round_inverse
  import mix_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORDS*W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORDS*W-1:0]   out_data,
  output logic                 busy
);

  localparam logic [7:0]       c_last_round = 8'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(WORDS - 1);

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [7:0]                r_round;
  logic [WORDS-1:0][W-1:0]   r_regs;
  logic [WORDS*W-1:0]        r_out_data;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;

  alu_op_t                   w_op;
  logic [IDX_W-1:0]          w_nb_idx;
  logic [W-1:0]              w_word_new;
  logic [WORDS-1:0][W-1:0]   w_regs_next;

  // Undo runs in reverse word order for B and A so each neighbour still holds
  // the value the forward pass read.
  always_comb begin
    w_op     = OP_PASS;
    w_nb_idx = r_idx;
    case (r_state)
      INV_C: w_op = OP_INV_C;
      INV_B: begin
        w_op     = OP_INV_B;
        w_nb_idx = r_idx + IDX_W'(XOR_DIST);
      end
      INV_A: begin
        w_op     = OP_INV_A;
        w_nb_idx = r_idx - IDX_W'(1);
      end
      default: w_op = OP_PASS;
    endcase
  end

  mix_word_alu u_alu (
    .i_op   (w_op),
    .i_idx  (r_idx),
    .i_word (r_regs[r_idx]),
    .i_nb   (r_regs[w_nb_idx]),
    .o_word (w_word_new)
  );

  always_comb begin
    w_regs_next        = r_regs;
    w_regs_next[r_idx] = w_word_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_round     <= '0;
      r_regs      <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_regs     <= in_data;
            r_idx      <= '0;
            r_round    <= '0;
            r_state    <= INV_C;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        INV_C: begin
          r_regs <= w_regs_next;
          if (r_idx == c_last_idx) r_state <= INV_B;
          else                     r_idx   <= r_idx + IDX_W'(1);
        end
        INV_B: begin
          r_regs <= w_regs_next;
          if (r_idx == '0) r_state <= INV_A;
          else             r_idx   <= r_idx - IDX_W'(1);
          if (r_idx == '0) r_idx   <= c_last_idx;
        end
        INV_A: begin
          r_regs <= w_regs_next;
          if (r_idx != '0) begin
            r_idx <= r_idx - IDX_W'(1);
          end else if (r_round == c_last_round) begin
            r_state     <= DONE;
            r_out_data  <= w_regs_next;
            r_out_valid <= 1'b1;
          end else begin
            r_round <= r_round + 8'd1;
            r_state <= INV_C;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    assert (consts_ok() && (ROUNDS >= 1) && (ROUNDS <= 255));
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mix_round_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mix_round_inverse : scoreboard bench for ROUNDS=4 and ROUNDS=1 units    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mix_round_inverse;

  localparam int TB_K [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  localparam int TB_C [8] = '{5, 7, 11, 13, 17, 19, 23, 29};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic         in_ready4, out_valid4, busy4;
  logic [255:0] in_data4 = '0;
  logic [255:0] out_data4;
  logic         in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic         in_ready1, out_valid1, busy1;
  logic [255:0] in_data1 = '0;
  logic [255:0] out_data1;

  mix_round_inverse #(.ROUNDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .busy(busy4)
  );

  mix_round_inverse #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1)
  );

  logic [255:0] exp4_q [$];
  logic [255:0] exp1_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name, input int got, input int limit);
    n_vec++;
    n_err++;
    $display("FAIL %s: waited %0d cycles, limit %0d", name, got, limit);
  endtask

  // Forward round F applied 'rounds' times.
  function automatic logic [255:0] fwd(input logic [255:0] s, input int rounds);
    logic [31:0]  o [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) o[i] = s[32*i +: 32];
    for (int k = 0; k < rounds; k++) begin
      for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i + 7) % 8];
      for (int i = 0; i < 8; i++) o[i] = o[i] ^ (o[(i + 3) % 8] << 16);
      for (int i = 0; i < 8; i++) o[i] = o[i] * 32'(TB_K[i]) + 32'(TB_C[i]);
    end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = o[i];
    return r;
  endfunction

  always @(negedge clk) begin : mon
    logic [255:0] e;
    if (rst_n && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r4_spurious_output: got %0h expected no output", out_data4);
      end else begin
        e = exp4_q.pop_front();
        check("r4_out_data", out_data4, e);
      end
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r1_spurious_output: got %0h expected no output", out_data1);
      end else begin
        e = exp1_q.pop_front();
        check("r1_out_data", out_data1, e);
      end
    end
  end

  task automatic send(input int sel, input logic [255:0] data, input logic [255:0] exp);
    int t;
    t = 0;
    while (((sel == 4) ? !in_ready4 : !in_ready1) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) begin
      fail_bound("send_wait_ready", t, 500);
      return;
    end
    if (sel == 4) begin in_data4 = data; in_valid4 = 1'b1; exp4_q.push_back(exp); end
    else          begin in_data1 = data; in_valid1 = 1'b1; exp1_q.push_back(exp); end
    @(posedge clk); #1;
    if (sel == 4) in_valid4 = 1'b0;
    else          in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp4_q.size() != 0 || exp1_q.size() != 0 || !in_ready4 || !in_ready1) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) begin
      fail_bound("drain", t, 2000);
      exp4_q.delete();
      exp1_q.delete();
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [255:0] d, d2, orig;
    int           n;
    logic         busy_ok;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  in_ready4,  1'b1);
    check("reset_out_valid", out_valid4, 1'b0);
    check("reset_busy",      busy4,      1'b0);
    check("reset_out_data",  out_data4,  '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ROUNDS=1: C[] undoes to zero; word0=1 hand-propagated through one F.
    send(1, {32'd29, 32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5}, '0);
    send(1, {32'h170034, 32'h13002A, 32'h110024, 32'h0D001E,
             32'h0B0018, 32'h070012, 32'h05000C, 32'h030008}, 256'd1);
    drain();

    // ROUNDS=4 directed originals
    send(4, fwd('0, 4), '0);
    send(4, fwd('1, 4), '1);
    send(4, fwd(256'h1, 4), 256'h1);
    d = 256'h8000_0000_0000_FFFF_FFFF_0000_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send(4, fwd(d, 4), d);
    drain();

    // Latency: accept edge is cycle 0, out_valid must appear after edge 96.
    d = 256'hCAFE_F00D_1234_5678_0000_0001_8000_0000_FFFF_FFFE_0F0F_0F0F_A5A5_A5A5_5A5A_5A5A;
    in_data4 = fwd(d, 4); in_valid4 = 1'b1; exp4_q.push_back(d);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("lat_busy_after_accept", busy4, 1'b1);
    check("lat_in_ready_after_accept", in_ready4, 1'b0);
    n = 0; busy_ok = 1'b1;
    while (!out_valid4 && n < 300) begin
      @(posedge clk); #1; n++;
      if (!busy4) busy_ok = 1'b0;
    end
    check("latency_cycles", 256'(n), 256'd96);
    check("lat_busy_held", busy_ok, 1'b1);
    drain();

    // Backpressure with in_valid held high throughout.
    d  = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    d2 = 256'h0246_8ACE_1357_9BDF_FDB9_7531_ECA8_6420_0000_0000_FFFF_FFFF_0001_0000_0000_0001;
    out_ready4 = 1'b0;
    in_data4 = fwd(d, 4); in_valid4 = 1'b1; exp4_q.push_back(d);
    @(posedge clk); #1;
    in_data4 = fwd(d2, 4);
    n = 0;
    while (!out_valid4 && n < 300) begin @(posedge clk); #1; n++; end
    check("bp_reach_done", out_valid4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid4, 1'b1);
      check("bp_hold_data",  out_data4,  d);
      check("bp_no_accept",  in_ready4,  1'b0);
    end
    out_ready4 = 1'b1; exp4_q.push_back(d2);
    @(posedge clk); #1;
    check("bp_valid_drop",   out_valid4, 1'b0);
    check("bp_ready_return", in_ready4,  1'b1);
    check("bp_busy_low",     busy4,      1'b0);
    @(posedge clk); #1;
    check("bp_second_accept", in_ready4, 1'b0);
    in_valid4 = 1'b0;
    drain();

    // Asynchronous reset 40 cycles into a job; no output may appear for it.
    d = 256'h7777_0000_3333_0000_1111_0000_5555_0000_9999_0000_BBBB_0000_DDDD_0000_FFFF_0000;
    in_data4 = fwd(d, 4); in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_in_ready",  in_ready4,  1'b1);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_busy",      busy4,      1'b0);
    check("rst_out_data",  out_data4,  '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready4, 1'b1);
    check("post_rst_busy",     busy4,     1'b0);
    send(4, fwd(d, 4), d);
    drain();

    for (int i = 0; i < 100; i++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      send(4, fwd(orig, 4), orig);
      if (i % 10 == 0) send(1, fwd(orig, 1), orig);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
